// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage: PC generation, single-outstanding imem fetch, 1-entry skid buffer and IF/ID register.
// Latency: a response seen at a clock edge is presented on instrD_o/PCD_o/validD_o right after that edge.
// Backpressure: stallD_i holds IF/ID. One stalled response goes to the skid buffer. While it is full, no new request is issued.
// Ports: clk/rst (async active-high); imem_req_o/imem_addr_o/imem_ready_i request side;
//   imem_rvalid_i/imem_rdata_i response side; redirectE_i/redirectPCE_i from execute;
//   stallD_i/flushD_i from hazard unit; instrD_o/PCD_o/PCPlus4D_o/validD_o to decode.
// Optional macro FETCH_MISALIGN_CHECK_EN adds misalignD_o and a HALT state for misaligned redirect targets.
module fetch_decode_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_ready_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  redirectE_i,
  input  logic [DATA_WIDTH-1:0] redirectPCE_i,
  input  logic                  stallD_i,
  input  logic                  flushD_i,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic                  misalignD_o,
`endif
  output logic [DATA_WIDTH-1:0] instrD_o,
  output logic [DATA_WIDTH-1:0] PCD_o,
  output logic [DATA_WIDTH-1:0] PCPlus4D_o,
  output logic                  validD_o
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_DISCARD
`ifdef FETCH_MISALIGN_CHECK_EN
    , S_HALT
`endif
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_pc, w_pc_nxt;
  logic [DATA_WIDTH-1:0] r_req_pc;
  logic                  r_skid_vld;
  logic [DATA_WIDTH-1:0] r_skid_instr, r_skid_pc;
  logic [DATA_WIDTH-1:0] r_instrD, r_pcD;
  logic                  r_validD;
  logic                  w_req, w_accept, w_resp, w_outstanding;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic                  r_mis_pend, r_misalignD;
  logic                  w_misalign;
  assign w_misalign  = redirectE_i && (redirectPCE_i[1:0] != 2'b00);
  assign misalignD_o = r_misalignD;
`endif

  // A request stays off while the skid buffer is occupied so that at most one
  // undelivered instruction ever exists downstream of memory.
  assign w_req    = (r_state == S_REQ) && !r_skid_vld;
  assign w_accept = w_req && imem_ready_i;
  // Only WAIT delivers. Responses seen in any other state are stale and ignored.
  assign w_resp   = (r_state == S_WAIT) && imem_rvalid_i;
  // A response is still in flight after this edge if WAIT/DISCARD sees no rvalid now.
  // If rvalid and a redirect land together, the response is consumed here,
  // so DISCARD would never be released.
  assign w_outstanding = ((r_state == S_WAIT) || (r_state == S_DISCARD)) && !imem_rvalid_i;

  assign imem_req_o  = w_req;
  assign imem_addr_o = r_pc;
  assign instrD_o    = r_instrD;
  assign PCD_o       = r_pcD;
  assign PCPlus4D_o  = r_pcD + PC_STEP;
  assign validD_o    = r_validD;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      S_BOOT:    w_state_nxt = S_REQ;
      S_REQ: begin
        if (w_accept) begin
          w_state_nxt = S_WAIT;
          w_pc_nxt    = r_pc + PC_STEP;
        end
      end
      S_WAIT:    if (imem_rvalid_i) w_state_nxt = S_REQ;
      S_DISCARD: if (imem_rvalid_i) w_state_nxt = S_REQ;
`ifdef FETCH_MISALIGN_CHECK_EN
      S_HALT:    w_state_nxt = S_HALT;
`endif
      default:   w_state_nxt = S_BOOT;
    endcase
    // Redirect wins over the accept's pc+4.
    if (redirectE_i) begin
      w_pc_nxt    = redirectPCE_i & ALIGN_MASK;
      w_state_nxt = (w_accept || w_outstanding) ? S_DISCARD : S_REQ;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (w_misalign) begin
        w_pc_nxt    = redirectPCE_i;
        w_state_nxt = S_HALT;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_BOOT;
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_accept) r_req_pc <= r_pc;
    end
  end

  // IF/ID register and skid buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid_vld   <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_instrD     <= NOP_INSTR;
      r_pcD        <= '0;
      r_validD     <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      r_mis_pend   <= 1'b0;
      r_misalignD  <= 1'b0;
`endif
    end else if (redirectE_i || flushD_i) begin
      r_skid_vld <= 1'b0;
      r_instrD   <= NOP_INSTR;
      r_validD   <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      r_misalignD <= 1'b0;
      if (redirectE_i) r_mis_pend <= w_misalign;
`endif
    end else if (stallD_i) begin
      // Skid is empty here whenever w_resp is set: nothing is requested while it is full.
      if (w_resp) begin
        r_skid_vld   <= 1'b1;
        r_skid_instr <= imem_rdata_i;
        r_skid_pc    <= r_req_pc;
      end
`ifdef FETCH_MISALIGN_CHECK_EN
    end else if (r_mis_pend) begin
      r_mis_pend  <= 1'b0;
      r_misalignD <= 1'b1;
      r_instrD    <= NOP_INSTR;
      r_pcD       <= r_pc;
      r_validD    <= 1'b1;
`endif
    end else begin
`ifdef FETCH_MISALIGN_CHECK_EN
      r_misalignD <= 1'b0;
`endif
      if (r_skid_vld) begin
        r_skid_vld <= 1'b0;
        r_instrD   <= r_skid_instr;
        r_pcD      <= r_skid_pc;
        r_validD   <= 1'b1;
      end else if (w_resp) begin
        r_instrD <= imem_rdata_i;
        r_pcD    <= r_req_pc;
        r_validD <= 1'b1;
      end else begin
        // Bubble: PC fields keep their last value.
        r_instrD <= NOP_INSTR;
        r_validD <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage with a 1-cycle-latency memory model
// that can be replaced by hand-driven responses (mem_en=0).
module tb_fetch_decode_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i = 1'b1;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirectE_i = 1'b0;
  logic [31:0] redirectPCE_i = 32'h0;
  logic        stallD_i = 1'b0;
  logic        flushD_i = 1'b0;
  logic [31:0] instrD_o, PCD_o, PCPlus4D_o;
  logic        validD_o;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalignD_o;
`endif

  logic        mem_en = 1'b1;
  logic        man_rvalid = 1'b0;
  logic [31:0] man_rdata = 32'h0;
  logic        auto_rvalid = 1'b0;
  logic [31:0] auto_rdata = 32'h0;
  logic        s_acc;
  logic [31:0] s_data;

  int total = 0;
  int bad = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  assign imem_rvalid_i = mem_en ? auto_rvalid : man_rvalid;
  assign imem_rdata_i  = mem_en ? auto_rdata  : man_rdata;

  fetch_decode_stage dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ready_i  (imem_ready_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirectE_i   (redirectE_i),
    .redirectPCE_i (redirectPCE_i),
    .stallD_i      (stallD_i),
    .flushD_i      (flushD_i),
`ifdef FETCH_MISALIGN_CHECK_EN
    .misalignD_o   (misalignD_o),
`endif
    .instrD_o      (instrD_o),
    .PCD_o         (PCD_o),
    .PCPlus4D_o    (PCPlus4D_o),
    .validD_o      (validD_o)
  );

  always #5 clk = ~clk;

  // Memory: an accept seen at an edge returns addr^KEY for the following cycle.
  always begin
    @(posedge clk);
    s_acc  = imem_req_o && imem_ready_i;
    s_data = imem_addr_o ^ KEY;
    #1;
    auto_rvalid = s_acc;
    auto_rdata  = s_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    step(); step(); step();
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_instr", instrD_o, NOP);
    chk("rst_pcd", PCD_o, 32'h0);
    chk("rst_pc4", PCPlus4D_o, 32'h4);
    chk("rst_valid", 32'(validD_o), 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst_mis", 32'(misalignD_o), 32'd0);
`endif
    rst = 1'b0;
    #1 chk("boot_req", 32'(imem_req_o), 32'd0);
    step(); // E1
    chk("first_req", 32'(imem_req_o), 32'd1);
    chk("first_addr", imem_addr_o, 32'h0);
    step(); // E2 accept 0
    chk("wait_req", 32'(imem_req_o), 32'd0);
    step(); // E3 deliver 0
    chk("d0_valid", 32'(validD_o), 32'd1);
    chk("d0_pcd", PCD_o, 32'h0);
    chk("d0_instr", instrD_o, 32'hA5A5_0000);
    chk("d0_pc4", PCPlus4D_o, 32'h4);
    chk("d0_addr", imem_addr_o, 32'h4);
    step(); // E4 bubble
    chk("b0_valid", 32'(validD_o), 32'd0);
    chk("b0_instr", instrD_o, NOP);
    chk("b0_pcd_hold", PCD_o, 32'h0);
    step(); // E5
    chk("d4_valid", 32'(validD_o), 32'd1);
    chk("d4_pcd", PCD_o, 32'h4);
    chk("d4_instr", instrD_o, 32'hA5A5_0004);
    step(); // E6
    chk("b1_valid", 32'(validD_o), 32'd0);
    step(); // E7
    chk("d8_pcd", PCD_o, 32'h8);
    chk("d8_instr", instrD_o, 32'hA5A5_0008);
    chk("d8_addr", imem_addr_o, 32'hC);

    // Stall across an outstanding response: it parks in the skid buffer.
    stallD_i = 1'b1;
    step(); // E8 accept C
    chk("st_hold_pcd", PCD_o, 32'h8);
    step(); // E9 response into skid
    chk("st_req_off", 32'(imem_req_o), 32'd0);
    chk("st_hold_valid", 32'(validD_o), 32'd1);
    step(); // E10
    chk("st_req_off2", 32'(imem_req_o), 32'd0);
    chk("st_hold_instr", instrD_o, 32'hA5A5_0008);
    step(); // E11
    chk("st_hold_pcd2", PCD_o, 32'h8);
    stallD_i = 1'b0;
    step(); // E12 skid drains
    chk("skid_pcd", PCD_o, 32'hC);
    chk("skid_instr", instrD_o, 32'hA5A5_000C);
    chk("skid_valid", 32'(validD_o), 32'd1);
    chk("skid_next_addr", imem_addr_o, 32'h10);
    step(); // E13
    chk("skid_b_valid", 32'(validD_o), 32'd0);
    step(); // E14
    chk("d10_pcd", PCD_o, 32'h10);
    chk("d10_instr", instrD_o, 32'hA5A5_0010);

    // Redirect while waiting; stale response comes later and must be dropped.
    mem_en = 1'b0;
    step(); // E15 accept 14
    chk("rd_wait_req", 32'(imem_req_o), 32'd0);
    redirectE_i = 1'b1; redirectPCE_i = 32'h100;
    step(); // E16
    chk("rd_addr", imem_addr_o, 32'h100);
    chk("rd_discard_req", 32'(imem_req_o), 32'd0);
    redirectE_i = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF;
    step(); // E17 stale dropped
    chk("rd_stale_valid", 32'(validD_o), 32'd0);
    chk("rd_stale_instr", instrD_o, NOP);
    chk("rd_req_again", 32'(imem_req_o), 32'd1);
    man_rvalid = 1'b0; mem_en = 1'b1;
    step(); // E18
    chk("rd_b_valid", 32'(validD_o), 32'd0);
    step(); // E19
    chk("rd_pcd", PCD_o, 32'h100);
    chk("rd_instr", instrD_o, 32'hA5A5_0100);
    chk("rd_pc4", PCPlus4D_o, 32'h104);

    // Flush beats stall.
    flushD_i = 1'b1; stallD_i = 1'b1;
    step(); // E20
    chk("fl_valid", 32'(validD_o), 32'd0);
    chk("fl_instr", instrD_o, NOP);
    flushD_i = 1'b0; stallD_i = 1'b0;
    step(); // E21
    chk("fl_next_pcd", PCD_o, 32'h104);
    chk("fl_next_valid", 32'(validD_o), 32'd1);

    // Reset mid-transaction, then a stale response after release.
    mem_en = 1'b0;
    step(); // E22 accept 108
    rst = 1'b1;
    #1;
    chk("mrst_req", 32'(imem_req_o), 32'd0);
    chk("mrst_addr", imem_addr_o, 32'h0);
    chk("mrst_valid", 32'(validD_o), 32'd0);
    chk("mrst_pcd", PCD_o, 32'h0);
    step(); // E23
    rst = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hBAD0_BAD0;
    step(); // E24
    chk("mrst_stale_valid", 32'(validD_o), 32'd0);
    chk("mrst_restart_req", 32'(imem_req_o), 32'd1);
    chk("mrst_restart_addr", imem_addr_o, 32'h0);
    man_rvalid = 1'b0; mem_en = 1'b1;
    step(); // E25
    step(); // E26
    chk("mrst_d0_pcd", PCD_o, 32'h0);
    chk("mrst_d0_instr", instrD_o, 32'hA5A5_0000);
    chk("mrst_d0_valid", 32'(validD_o), 32'd1);

    // Redirect with a same-cycle accept, to the last word: PC wraps to 0.
    redirectE_i = 1'b1; redirectPCE_i = 32'hFFFF_FFFC;
    step(); // E27
    chk("wr_addr", imem_addr_o, 32'hFFFF_FFFC);
    chk("wr_discard_req", 32'(imem_req_o), 32'd0);
    redirectE_i = 1'b0;
    step(); // E28 stale dropped
    chk("wr_stale_valid", 32'(validD_o), 32'd0);
    chk("wr_req", 32'(imem_req_o), 32'd1);
    step(); // E29
    chk("wr_pc_wrap", imem_addr_o, 32'h0);
    step(); // E30
    chk("wr_pcd", PCD_o, 32'hFFFF_FFFC);
    chk("wr_pc4", PCPlus4D_o, 32'h0);
    chk("wr_instr", instrD_o, 32'h5A5A_FFFC);

`ifdef FETCH_MISALIGN_CHECK_EN
    redirectE_i = 1'b1; redirectPCE_i = 32'h102;
    step(); // E31 enter HALT
    chk("mis_addr", imem_addr_o, 32'h102);
    chk("mis_req0", 32'(imem_req_o), 32'd0);
    chk("mis_flag0", 32'(misalignD_o), 32'd0);
    redirectE_i = 1'b0;
    step(); // E32
    chk("mis_valid", 32'(validD_o), 32'd1);
    chk("mis_instr", instrD_o, NOP);
    chk("mis_pcd", PCD_o, 32'h102);
    chk("mis_flag", 32'(misalignD_o), 32'd1);
    chk("mis_req1", 32'(imem_req_o), 32'd0);
    step(); // E33
    chk("mis_flag_clr", 32'(misalignD_o), 32'd0);
    chk("mis_b_valid", 32'(validD_o), 32'd0);
    chk("mis_req2", 32'(imem_req_o), 32'd0);
    step(); // E34
    chk("mis_req3", 32'(imem_req_o), 32'd0);
    redirectE_i = 1'b1; redirectPCE_i = 32'h200;
    step(); // E35
    chk("mis_exit_req", 32'(imem_req_o), 32'd1);
    chk("mis_exit_addr", imem_addr_o, 32'h200);
    redirectE_i = 1'b0;
    step(); // E36
    step(); // E37
    chk("mis_d_pcd", PCD_o, 32'h200);
    chk("mis_d_instr", instrD_o, 32'hA5A5_0200);
    chk("mis_d_flag", 32'(misalignD_o), 32'd0);
`else
    // Low target bits are masked off.
    redirectE_i = 1'b1; redirectPCE_i = 32'h203;
    step(); // E31
    chk("msk_addr", imem_addr_o, 32'h200);
    chk("msk_req", 32'(imem_req_o), 32'd0);
    redirectE_i = 1'b0;
    step(); // E32
    chk("msk_stale_valid", 32'(validD_o), 32'd0);
    step(); // E33
    step(); // E34
    chk("msk_pcd", PCD_o, 32'h200);
    chk("msk_instr", instrD_o, 32'hA5A5_0200);
    chk("msk_valid", 32'(validD_o), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_decode_stage.md
Name: fetch_decode_stage

Overview:
- Fetch stage plus IF/ID pipeline register. It generates the PC, talks to instruction memory over a req/ready + rvalid handshake, and presents instructions to decode.
- Sits directly upstream of the decode→execute register. It produces PCD, InstrD and PCPlus4D, which decode turns into the D-side control and data signals.
- Handles stall, flush and redirect from branch/JAL/JALR resolved in execute.

Parameters:
- DATA_WIDTH, 32, width of PC, address and instruction.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, instruction driven on a bubble (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  DATA_WIDTH  fetch address, word-aligned.
- imem_ready_i  in  1  memory accepts request this cycle.
- imem_rvalid_i  in  1  response valid.
- imem_rdata_i  in  DATA_WIDTH  response instruction.
- redirectE_i  in  1  taken branch/JAL/JALR from execute.
- redirectPCE_i  in  DATA_WIDTH  redirect target.
- stallD_i  in  1  hold IF/ID contents (hazard unit).
- flushD_i  in  1  kill IF/ID contents.
- instrD_o  out  DATA_WIDTH  instruction to decode.
- PCD_o  out  DATA_WIDTH  PC of instrD_o.
- PCPlus4D_o  out  DATA_WIDTH  PCD_o + 4, mod 2^DATA_WIDTH.
- validD_o  out  1  instrD_o is a real instruction.

Behaviour:
- Reset (async, any time, including mid-transaction):
  - pc=RESET_PC, state=BOOT, skid buffer empty.
  - instrD_o=NOP_INSTR, PCD_o=0, PCPlus4D_o=4, validD_o=0.
  - imem_req_o=0, imem_addr_o=RESET_PC.
- imem_addr_o always equals pc. At most one request is outstanding.
- A request is accepted when imem_req_o && imem_ready_i. The response arrives on a later cycle, minimum 1. rvalid in the acceptance cycle is illegal.
- States:
  - BOOT: req=0. Next cycle goes to REQ. This gives one idle cycle after reset release.
  - REQ: req=1 unless the skid buffer is full. On accept: latch reqPC=pc, pc<=pc+4, go to WAIT.
  - WAIT: req=0. On rvalid: deliver {imem_rdata_i, reqPC}, go to REQ. An accept and an rvalid in the same cycle are not possible.
  - DISCARD: req=0. The next rvalid is dropped, then go to REQ.
- Delivery:
  - If stallD_i=0, the IF/ID register loads the response: validD=1.
  - If stallD_i=1, the response goes to the 1-entry skid buffer.
  - When the buffer is full and stallD_i=0, IF/ID loads from the buffer first and the buffer empties.
  - While the buffer is full, REQ holds req=0.
  - With no response and no buffered entry and stallD_i=0, IF/ID loads a bubble: NOP_INSTR, validD=0, PC fields hold.
- Priority: redirectE_i > flushD_i > stallD_i.
- Redirect:
  - pc<=redirectPCE_i & ~3.
  - IF/ID becomes a bubble and the skid buffer is cleared.
  - If the state is WAIT, or an accept happens in this cycle, go to DISCARD. Otherwise go to REQ.
  - The redirect overrides any same-cycle accept's pc+4 update.
- flushD_i (no redirect): IF/ID becomes a bubble and the skid buffer is cleared. The fetch FSM is unaffected.
- stallD_i alone: IF/ID outputs hold exactly. The FSM keeps running until the skid buffer fills.
- PC wrap: 32'hFFFF_FFFC + 4 = 0, with no error.
- Best-case throughput: 1 instruction per 2 cycles for 1-cycle memory latency.

Optional Feature:
FETCH_MISALIGN_CHECK_EN
- Defined:
  - Adds port misalignD_o (out, 1), reset value 0.
  - A redirect with redirectPCE_i[1:0] != 0 sets pc to the unmasked target and enters state HALT. HALT has req=0 and issues no memory access.
  - The next IF/ID load is validD=1, instrD=NOP_INSTR, PCD=target, misalignD_o=1.
  - HALT persists until the next redirect. misalignD_o clears on the next non-stalled IF/ID load.
- Undefined: the low 2 target bits are silently masked. There is no HALT state and no port.

Test Plan:
- Release reset; memory has ready=1 and returns rvalid 1 cycle after accept with data=addr^32'hA5A5_0000 → first req in cycle 2; PCD_o=0, 4, 8 with matching instrD_o; validD pulses every 2nd cycle.
- stallD_i=1 for 4 cycles while a response is outstanding → IF/ID holds; the response lands in skid; req stays 0. After release, the buffered instr appears first with no loss or duplicate.
- redirectE_i=1, target 32'h100, in a WAIT cycle → the stale rvalid is dropped; next PCD_o=32'h100; no instruction from the old stream reaches decode.
- flushD_i and stallD_i both high → bubble: validD_o=0, instrD_o=32'h0000_0013.
- Assert rst in WAIT, release, then inject the stale rvalid → ignored; fetch restarts at RESET_PC.
- With FETCH_MISALIGN_CHECK_EN: redirect to 32'h102 → validD=1, misalignD_o=1, PCD_o=32'h102, no imem_req_o until redirect to 32'h200.
